// File: rtl/vram8_blitter_pkg.sv
// Shared definitions for the VRAM8 copy/fill blitter: engine states,
// register window indices and the CTRL / status bit positions.
package vram8_blitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LAT  = 3'd2,
    ST_WR   = 3'd3,
    ST_FILL = 3'd4
  } state_t;

  // Register window
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL command bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_MODE     = 1;  // 0 copy, 1 fill
  localparam int CTRL_ABORT    = 2;
  localparam int CTRL_FILL_LSB = 8;

  // Status word bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;
  localparam int STAT_CNT_LSB = 16;

endpackage

// File: rtl/vram_port_mux.sv
// Shared-port arbiter for a VRAM CPU port: the external owner (MemoryUnit)
// has absolute priority; otherwise the local engine drives the port.
module vram_port_mux #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              mu_sel,
  input  logic [ADDR_W-1:0] mu_addr,
  input  logic [DATA_W-1:0] mu_d,
  input  logic              mu_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_d,
  input  logic              eng_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_d,
  output logic              vram_we
);

  // Select the port owner for this cycle
  always_comb begin
    if (mu_sel) begin
      vram_addr = mu_addr;
      vram_d    = mu_d;
      vram_we   = mu_we;
    end else begin
      vram_addr = eng_addr;
      vram_d    = eng_d;
      vram_we   = eng_we;
    end
  end

endmodule

// File: rtl/vram8_blitter.sv
// VRAM8 copy/fill engine. Configured through a four-register window, it
// moves bytes VRAM8->VRAM8 or writes a constant, yielding the port to the
// MemoryUnit whenever mu_sel is high, and pulses done on completion.
module vram8_blitter
  import vram8_blitter_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_data,
  output logic [31:0]       cfg_q,
  input  logic              mu_sel,
  input  logic [ADDR_W-1:0] mu_addr,
  input  logic [DATA_W-1:0] mu_d,
  input  logic              mu_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_d,
  output logic              vram_we,
  input  logic [DATA_W-1:0] vram_q,
  output logic              done
);

  state_t state, state_next;

  logic [ADDR_W-1:0] src_reg, dst_reg, len_reg;  // programmed values
  logic [ADDR_W-1:0] src, dst, cnt;              // working counters
  logic [DATA_W-1:0] hold;                       // byte in flight (copy)
  logic [DATA_W-1:0] fill_val;
  logic              done_sticky, aborted_sticky;

  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_d;
  logic              eng_we;

  logic grant, busy, ctrl_wr, start_cmd, abort_cmd, last, wr_fire;
  logic unused_cfg;

  assign grant     = ~mu_sel;
  assign busy      = (state != ST_IDLE);
  assign ctrl_wr   = cfg_we && (cfg_addr == REG_CTRL);
  // Abort wins over start when both are set in one CTRL write.
  assign abort_cmd = ctrl_wr && cfg_data[CTRL_ABORT] && busy;
  assign start_cmd = ctrl_wr && cfg_data[CTRL_START] && !cfg_data[CTRL_ABORT] && !busy;
  assign last      = (cnt == ADDR_W'(1));
  assign wr_fire   = grant && ((state == ST_WR) || (state == ST_FILL));
  assign unused_cfg = ^cfg_data;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: stall on lost grant, abort forces IDLE
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start_cmd && (len_reg != '0))
                 state_next = cfg_data[CTRL_MODE] ? ST_FILL : ST_RD;
      ST_RD:   if (grant) state_next = ST_LAT;
      ST_LAT:  state_next = ST_WR;
      ST_WR:   if (grant) state_next = last ? ST_IDLE : ST_RD;
      ST_FILL: if (grant && last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (abort_cmd) state_next = ST_IDLE;
  end

  // Engine port request per state; the mux decides whether it is granted
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    eng_addr = '0;
    eng_d    = '0;
    eng_we   = 1'b0;
    unique case (state)
      ST_RD:   eng_addr = src;
      ST_WR:   begin eng_addr = dst; eng_d = hold;     eng_we = 1'b1; end
      ST_FILL: begin eng_addr = dst; eng_d = fill_val; eng_we = 1'b1; end
      default: ;
    endcase
  end

  // Register window, counters, hold byte and completion flags
  always_ff @(posedge clk) begin
    if (reset) begin
      src_reg        <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      src            <= '0;
      dst            <= '0;
      cnt            <= '0;
      hold           <= '0;
      fill_val       <= '0;
      done           <= 1'b0;
      done_sticky    <= 1'b0;
      aborted_sticky <= 1'b0;
    end else begin
      done <= 1'b0;

      if (cfg_we) begin
        unique case (cfg_addr)
          REG_SRC: src_reg <= cfg_data[ADDR_W-1:0];
          REG_DST: dst_reg <= cfg_data[ADDR_W-1:0];
          REG_LEN: len_reg <= cfg_data[ADDR_W-1:0];
          default: ;
        endcase
      end

      // A zero-length start completes immediately without touching the port.
      if (start_cmd) begin
        src            <= src_reg;
        dst            <= dst_reg;
        cnt            <= len_reg;
        fill_val       <= cfg_data[CTRL_FILL_LSB +: DATA_W];
        aborted_sticky <= 1'b0;
        done_sticky    <= (len_reg == '0);
        done           <= (len_reg == '0);
      end

      // vram_q now holds the byte addressed during the granted RD cycle.
      if (state == ST_LAT) hold <= vram_q;

      // A granted write always completes, even alongside an abort.
      if (wr_fire) begin
        if (state == ST_WR) src <= src + ADDR_W'(1);
        dst <= dst + ADDR_W'(1);
        cnt <= cnt - ADDR_W'(1);
        if (last && !abort_cmd) begin
          done        <= 1'b1;
          done_sticky <= 1'b1;
        end
      end

      if (abort_cmd) aborted_sticky <= 1'b1;
    end
  end

  // Status word, independent of cfg_addr
  always_comb begin
    cfg_q                           = '0;
    cfg_q[STAT_BUSY]                = busy;
    cfg_q[STAT_DONE]                = done_sticky;
    cfg_q[STAT_ABORTED]             = aborted_sticky;
    cfg_q[STAT_CNT_LSB +: ADDR_W]   = cnt;
  end

  vram_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .mu_sel    (mu_sel),
    .mu_addr   (mu_addr),
    .mu_d      (mu_d),
    .mu_we     (mu_we),
    .eng_addr  (eng_addr),
    .eng_d     (eng_d),
    .eng_we    (eng_we),
    .vram_addr (vram_addr),
    .vram_d    (vram_d),
    .vram_we   (vram_we)
  );

endmodule

// File: tb/tb_vram8_blitter.sv
// Self-checking bench for vram8_blitter. A behavioural VRAM8 sits on the
// port; expectations come from a transfer-level model (byte lists and a
// port-slot schedule) kept here.
module tb_vram8_blitter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 8;
  localparam int MEM_SIZE = 1 << ADDR_W;

  localparam logic [1:0] R_SRC  = 2'd0;
  localparam logic [1:0] R_DST  = 2'd1;
  localparam logic [1:0] R_LEN  = 2'd2;
  localparam logic [1:0] R_CTRL = 2'd3;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [31:0]       cfg_data;
  logic [31:0]       cfg_q;
  logic              mu_sel;
  logic [ADDR_W-1:0] mu_addr;
  logic [DATA_W-1:0] mu_d;
  logic              mu_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_d;
  logic              vram_we;
  logic [DATA_W-1:0] vram_q;
  logic              done;

  always #5 clk = ~clk;

  vram8_blitter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_q     (cfg_q),
    .mu_sel    (mu_sel),
    .mu_addr   (mu_addr),
    .mu_d      (mu_d),
    .mu_we     (mu_we),
    .vram_addr (vram_addr),
    .vram_d    (vram_d),
    .vram_we   (vram_we),
    .vram_q    (vram_q),
    .done      (done)
  );

  // VRAM8 CPU port: 1-cycle synchronous read
  logic [7:0] mem [MEM_SIZE];
  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_d;
    vram_q <= mem[vram_addr];
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic [7:0]  ref_mem [MEM_SIZE];
  wr_t         obs_q[$];
  int          done_q[$];
  int          cyc;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          stat_chk = 0;
  bit          we_zero_chk = 0;
  logic [31:0] exp_stat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: inputs already set; observe at negedge, advance past posedge
  task automatic tick();
    @(negedge clk);
    if (mu_sel)
      check("mu_pass", {9'd0, vram_we, vram_d, vram_addr}, {9'd0, mu_we, mu_d, mu_addr});
    if (!mu_sel && vram_we) obs_q.push_back('{vram_addr, vram_d});
    if (done) done_q.push_back(cyc);
    if (stat_chk) check("status", cfg_q, exp_stat);
    if (we_zero_chk) check("we_off", {31'd0, vram_we}, 32'd0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic mu_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    mu_sel = 1'b1; mu_we = 1'b1; mu_addr = a; mu_d = d;
    ref_mem[a] = d;
    tick();
    mu_sel = 1'b0; mu_we = 1'b0;
  endtask

  function automatic bit mu_at(input logic [127:0] pat, input int c);
    return (c >= 0 && c < 128) ? pat[c] : 1'b0;
  endfunction

  // Program and run one transfer, checking it against the model
  task automatic run_op(input bit fill, input logic [ADDR_W-1:0] src,
                        input logic [ADDR_W-1:0] dst, input logic [ADDR_W-1:0] len,
                        input logic [7:0] val, input logic [127:0] mu_pat,
                        input int busy_start_at);
    bit                port_q[$];
    bit                wr_q[$];
    int                exp_rem[$];
    wr_t               exp_q[$];
    int                i, last, exp_done, rem, n;
    logic [ADDR_W-1:0] a;

    // Expected byte stream: strictly ascending, wrapping addresses
    for (int k = 0; k < int'(len); k++) begin
      a = dst + ADDR_W'(k);
      if (fill) begin
        ref_mem[a] = val;
      end else begin
        ref_mem[a] = ref_mem[src + ADDR_W'(k)];
        port_q.push_back(1'b1); wr_q.push_back(1'b0);   // read
        port_q.push_back(1'b0); wr_q.push_back(1'b0);   // read latency
      end
      port_q.push_back(1'b1); wr_q.push_back(1'b1);     // write
      exp_q.push_back('{a, ref_mem[a]});
    end

    // Schedule: each slot needing the port waits out MemoryUnit cycles
    rem = int'(len); i = 0; last = 0;
    for (int c = 1; i < port_q.size(); c++) begin
      exp_rem.push_back(rem);
      if (!(port_q[i] && mu_at(mu_pat, c))) begin
        if (wr_q[i]) rem--;
        i++;
      end
      last = c;
    end
    exp_done = last + 1;

    obs_q.delete(); done_q.delete();
    cfg_write(R_SRC, 32'(src));
    cfg_write(R_DST, 32'(dst));
    cfg_write(R_LEN, 32'(len));

    cyc = 0;
    cfg_we = 1'b1; cfg_addr = R_CTRL; cfg_data = {16'h0, val, 6'h0, fill, 1'b1};
    tick();
    cfg_we = 1'b0;
    while (cyc <= exp_done + 2) begin
      mu_sel  = mu_at(mu_pat, cyc);
      mu_we   = mu_sel & 1'($urandom_range(0, 1));
      mu_addr = 14'h2000 | 14'($urandom_range(0, 255));
      mu_d    = 8'($urandom);
      if (cyc == busy_start_at) begin
        cfg_we = 1'b1; cfg_addr = R_CTRL; cfg_data = 32'h0000_A503;
      end
      stat_chk = 1'b1;
      exp_stat = (cyc <= last) ? {2'b0, 14'(exp_rem[cyc-1]), 16'h0001} : 32'h0000_0002;
      tick();
      cfg_we = 1'b0;
    end
    stat_chk = 1'b0; mu_sel = 1'b0; mu_we = 1'b0;

    check("done_count", done_q.size(), 1);
    if (done_q.size() > 0) check("done_cycle", done_q[0], exp_done);
    check("write_count", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      check("write", {10'd0, obs_q[k].addr, obs_q[k].data}, {10'd0, exp_q[k].addr, exp_q[k].data});
  endtask

  initial begin
    logic [ADDR_W-1:0] r_src, r_dst, r_len;
    logic [127:0]      pat;
    bit                r_fill;

    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    mu_sel = 1'b0; mu_addr = '0; mu_d = '0; mu_we = 1'b0;
    cyc = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cfg_q", cfg_q, 32'd0);
    check("rst_port", {9'd0, vram_we, vram_d, vram_addr}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill 0x100..0x103 with 0x5A, uncontended
    run_op(1'b1, 14'h0000, 14'h0100, 14'd4, 8'h5A, 128'h0, -1);
    check("fill_sticky", cfg_q, 32'h0000_0002);

    // Copy {1,2,3} from 0x10 to 0x200
    mu_write(14'h0010, 8'd1); mu_write(14'h0011, 8'd2); mu_write(14'h0012, 8'd3);
    run_op(1'b0, 14'h0010, 14'h0200, 14'd3, 8'h00, 128'h0, -1);

    // Fill with MemoryUnit owning the port for cycles 2..4
    run_op(1'b1, 14'h0000, 14'h0180, 14'd4, 8'hC3, 128'h1C, -1);

    // Address wrap at the top of VRAM8
    run_op(1'b1, 14'h0000, 14'h3FFE, 14'd4, 8'h99, 128'h0, -1);

    // Zero length: done next cycle, no writes
    run_op(1'b0, 14'h0000, 14'h0400, 14'd0, 8'h00, 128'h0, -1);

    // Second start mid-copy is ignored
    for (int k = 0; k < 6; k++) mu_write(14'h0020 + 14'(k), 8'($urandom));
    run_op(1'b0, 14'h0020, 14'h0220, 14'd6, 8'h00, 128'h0, 4);

    // Abort a 10-byte fill during its third write
    obs_q.delete(); done_q.delete();
    cfg_write(R_DST, 32'h0300);
    cfg_write(R_LEN, 32'd10);
    cyc = 0;
    cfg_we = 1'b1; cfg_addr = R_CTRL; cfg_data = 32'h0000_7703;
    tick();
    cfg_we = 1'b0;
    stat_chk = 1'b1;
    exp_stat = {2'b0, 14'd10, 16'h0001}; tick();
    exp_stat = {2'b0, 14'd9,  16'h0001}; tick();
    cfg_we = 1'b1; cfg_addr = R_CTRL; cfg_data = 32'h0000_0004;
    exp_stat = {2'b0, 14'd8,  16'h0001}; tick();
    cfg_we = 1'b0;
    exp_stat = {2'b0, 14'd7,  16'h0004};
    repeat (6) tick();
    stat_chk = 1'b0;
    check("abort_done", done_q.size(), 0);
    check("abort_writes", obs_q.size(), 3);
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      check("abort_write", {10'd0, obs_q[k].addr, obs_q[k].data},
            {10'd0, 14'h0300 + 14'(k), 8'h77});
      ref_mem[14'h0300 + 14'(k)] = 8'h77;
    end

    // Reset in the middle of a copy
    for (int k = 0; k < 5; k++) mu_write(14'h0040 + 14'(k), 8'($urandom));
    obs_q.delete(); done_q.delete();
    cfg_write(R_SRC, 32'h0040);
    cfg_write(R_DST, 32'h0500);
    cfg_write(R_LEN, 32'd5);
    cyc = 0;
    cfg_we = 1'b1; cfg_addr = R_CTRL; cfg_data = 32'h0000_0001;
    tick();
    cfg_we = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stat_chk = 1'b1; exp_stat = 32'd0; we_zero_chk = 1'b1;
    repeat (6) tick();
    stat_chk = 1'b0; we_zero_chk = 1'b0;
    ref_mem[14'h0500] = ref_mem[14'h0040];
    check("rst_done_none", done_q.size(), 0);
    check("rst_writes", obs_q.size(), 1);
    if (obs_q.size() > 0)
      check("rst_write", {10'd0, obs_q[0].addr, obs_q[0].data},
            {10'd0, 14'h0500, ref_mem[14'h0500]});

    // Randomised transfers with random MemoryUnit contention
    for (int t = 0; t < 8; t++) begin
      r_fill = 1'($urandom_range(0, 1));
      r_len  = 14'($urandom_range(1, 12));
      r_src  = 14'($urandom_range(0, 14'h1FF0));
      r_dst  = 14'($urandom_range(0, 14'h1FF0));
      pat    = '0;
      for (int b = 1; b < 128; b++) pat[b] = ($urandom_range(0, 3) == 0);
      if (!r_fill)
        for (int k = 0; k < int'(r_len); k++) mu_write(r_src + 14'(k), 8'($urandom));
      run_op(r_fill, r_src, r_dst, r_len, 8'($urandom), pat, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram8_blitter.md
# vram8_blitter

Copy/fill engine for the 8-bit VRAM (tile/pattern RAM) that shares the VRAM8 CPU-side port with the MemoryUnit. It is configured through a small register window, then moves bytes VRAM8→VRAM8 (copy) or writes a constant (fill) while the MemoryUnit keeps absolute priority on the port. It sits between the MemoryUnit's VRAM8 port signals and the VRAM8 instance, and it raises a one-cycle completion pulse that can be routed to a CPU interrupt input.

## Interface
Parameters:
- ADDR_W, 14: VRAM8 address width; all address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8: VRAM8 word width.

Ports:
- clk  in  1  system clock, same clock as the VRAM8 CPU port.
- reset  in  1  synchronous, active-high.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  2  register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL.
- cfg_data  in  32  write data.
- cfg_q  out  32  status word, independent of cfg_addr.
- mu_sel  in  1  MemoryUnit owns the VRAM8 port this cycle.
- mu_addr  in  ADDR_W  MemoryUnit address.
- mu_d  in  DATA_W  MemoryUnit write data.
- mu_we  in  1  MemoryUnit write enable.
- vram_addr  out  ADDR_W  to VRAM8 cpu_addr.
- vram_d  out  DATA_W  to VRAM8 cpu_d.
- vram_we  out  1  to VRAM8 cpu_we.
- vram_q  in  DATA_W  from VRAM8 cpu_q, which has 1-cycle synchronous read latency. The MemoryUnit takes this signal directly.
- done  out  1  one-cycle completion pulse.

## Operation
- Registers:
  - SRC, DST and LEN take cfg_data[ADDR_W-1:0].
  - A CTRL write acts as a command: bit0 start, bit1 mode (0 copy, 1 fill), bit2 abort, bits[15:8] fill value (latched on start).
- cfg_q layout: [0] busy, [1] done_sticky, [2] aborted_sticky, [29:16] remaining count, other bits 0.
- Port mux:
  - mu_sel=1: vram_* = mu_* and the blitter makes no access that cycle (stall).
  - mu_sel=0: vram_* = blitter outputs, with vram_we=0 when the engine is not writing.
- States: IDLE, RD, LAT, WR, FILL.
- IDLE:
  - Start with LEN=0: no access; done pulses next cycle and done_sticky is set.
  - Start with LEN>0: load the src, dst and cnt counters, clear both stickies, then go to RD (copy) or FILL (fill).
  - Start while busy is ignored.
- RD: drive vram_addr=src. If granted (mu_sel=0) go to LAT; otherwise stay in RD.
- LAT: capture vram_q into the hold register. No port use, so it never stalls. Go to WR.
- WR: drive dst, hold, we=1. If granted: src+1, dst+1, cnt-1; if cnt was 1 go to IDLE with done, else go to RD. If not granted, stay in WR.
- FILL: drive dst, fill value, we=1. If granted: dst+1, cnt-1; if cnt was 1 go to IDLE with done.
- Abort (CTRL bit2=1 while busy):
  - Enters IDLE the next cycle, sets aborted_sticky, no done pulse.
  - A write granted in that same cycle completes normally.
  - Abort overrides start in the same CTRL write.
- Overlapping copy regions are copied strictly ascending. No memmove semantics.

## Timing
- Reset values: vram_we=0, vram_addr=0, vram_d=0, done=0, cfg_q=0, state IDLE, all registers 0.
- Start to first port access: the cycle after the CTRL write.
- Uncontended throughput: copy 3 cycles/byte, fill 1 cycle/byte.
- done asserts the cycle after the last granted write, for exactly 1 cycle. busy falls in the same cycle.
- Each cycle with mu_sel=1 during RD/WR/FILL adds exactly one cycle. MemoryUnit timing is never altered.
- The MemoryUnit read-data path is unaffected: a blitter read never overlaps an MU read's result cycle, because vram_q always belongs to the previous cycle's owner.
- Reset mid-operation: IDLE next cycle, no done, no further writes.

## Structure
- Shared package vram8_blitter_pkg holds:
  - the state enum;
  - register index constants (REG_SRC=0, REG_DST=1, REG_LEN=2, REG_CTRL=3);
  - CTRL and status bit positions.
- Single module. The port mux is a separate small combinational sub-module, vram_port_mux, reused later for VRAM32/VRAMSPR.

## Test plan
- Fill: DST=0x100, LEN=4, value 0x5A, mu_sel=0 → writes at 0x100..0x103 on 4 consecutive cycles; done on cycle 5; cfg_q[1]=1.
- Copy: preload 0x10..0x12={1,2,3}, SRC=0x10, DST=0x200, LEN=3 → 0x200..0x202={1,2,3}; 9 cycles; single done pulse.
- Contention: fill LEN=4 with mu_sel=1 for 3 cycles mid-transfer → MU writes land unaltered; completion delayed exactly 3 cycles; 4 blitter writes total.
- Wrap: fill DST=0x3FFE, LEN=4 → writes at 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- LEN=0 and start-while-busy → LEN=0 gives done next cycle with no vram_we; a second start mid-copy is ignored and the count is unchanged.
- Abort/reset: abort after 2 of 10 fill bytes → exactly 2–3 writes, no done, aborted bit set. Reset mid-copy → vram_we=0 from the next cycle.
